// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache:
// FSM state encoding, geometry defaults and address-field width helpers.
package icache_assoc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_e;

    localparam int WAYS_D        = 2;
    localparam int SETS_D        = 32;
    localparam int BLOCK_BYTES_D = 16;
    localparam int ADDR_BITS_D   = 17;

    function automatic int off_w(int bb);
        return $clog2(bb);
    endfunction

    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int ab, int bb, int sets);
        return ab - $clog2(bb) - $clog2(sets);
    endfunction

    function automatic int way_w(int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side bus of the instruction cache.
// slave: cache side (fetch lookup in, refill requests out); master: core/memory side.
interface icache_assoc_if
    import icache_assoc_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_D
) ();
    logic                 fetch_valid;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic                 fetch_hit;
    logic [31:0]          inst_out;
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ack;
    logic [31:0]          mem_data;
    logic                 busy;

    modport master (
        output fetch_valid, fetch_addr, mem_ack, mem_data,
        input  fetch_hit, inst_out, mem_req, mem_addr, busy
    );

    modport slave (
        input  fetch_valid, fetch_addr, mem_ack, mem_data,
        output fetch_hit, inst_out, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state: touch a way to make it most recent,
// read the victim way of a set. Ports: en (global pause), clear, upd/upd_set/upd_way, rd_set -> victim.
module icache_plru
    import icache_assoc_pkg::*;
#(
    parameter int WAYS = WAYS_D,
    parameter int SETS = SETS_D
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  upd,
    input  logic [idx_w(SETS)-1:0] upd_set,
    input  logic [way_w(WAYS)-1:0] upd_way,
    input  logic [idx_w(SETS)-1:0] rd_set,
    output logic [way_w(WAYS)-1:0] victim
);
    localparam int LB = (WAYS > 1) ? WAYS - 1 : 1;

    logic [LB-1:0] bits_q [SETS];
    logic [LB-1:0] bits_d [SETS];
    logic [LB-1:0] nxt;
    logic [LB-1:0] rd;

    assign rd = bits_q[rd_set];

    // Each tree bit points at the half holding the victim.
    if (WAYS == 4) begin : g_w4
        assign nxt = upd_way[1]
            ? {~upd_way[0], bits_q[upd_set][1], 1'b0}
            : {bits_q[upd_set][2], ~upd_way[0], 1'b1};
        assign victim = rd[0] ? {1'b1, rd[2]} : {1'b0, rd[1]};
    end else if (WAYS == 2) begin : g_w2
        assign nxt    = ~upd_way;
        assign victim = rd;
    end else begin : g_w1
        assign nxt    = 1'b0;
        assign victim = 1'b0;
    end

    always_comb begin
        for (int s = 0; s < SETS; s++) bits_d[s] = bits_q[s];
        if (en) begin
            if (clear) begin
                for (int s = 0; s < SETS; s++) bits_d[s] = '0;
            end else if (upd) begin
                bits_d[upd_set] = nxt;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
        end else begin
            for (int s = 0; s < SETS; s++) bits_q[s] <= bits_d[s];
        end
    end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with one-halfword line overlap and word-serial refill.
// Ports: clk_in, rst_in (async high), rdy_in (pause), flush, bus (fetch lookup + refill handshake).
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS        = WAYS_D,
    parameter int SETS        = SETS_D,
    parameter int BLOCK_BYTES = BLOCK_BYTES_D,
    parameter int ADDR_BITS   = ADDR_BITS_D
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush,
    icache_assoc_if.slave bus
);
    localparam int OW    = off_w(BLOCK_BYTES);
    localparam int IW    = idx_w(SETS);
    localparam int TW    = tag_w(ADDR_BITS, BLOCK_BYTES, SETS);
    localparam int WW    = way_w(WAYS);
    localparam int WORDS = BLOCK_BYTES / 4 + 1;
    localparam int CW    = $clog2(WORDS);
    localparam int LW    = (BLOCK_BYTES + 2) * 8;
    localparam int FW    = WORDS * 32;

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;

    assign off = bus.fetch_addr[OW-1:0];
    assign idx = bus.fetch_addr[OW +: IW];
    assign tag = bus.fetch_addr[ADDR_BITS-1 -: TW];

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] valid_d [SETS];
    logic [TW-1:0]   tag_mem [WAYS][SETS];
    logic [LW-1:0]   data_mem [WAYS][SETS];

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        tag_q, tag_d;
    logic [WW-1:0]        vict_q, vict_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 drop_q, drop_d;

    logic [WAYS-1:0] way_hit;
    logic [WW-1:0]   hit_way;
    logic [LW-1:0]   hit_line;
    logic            any_hit;
    logic [WW-1:0]   plru_vict, new_vict;
    logic            plru_upd, wr_en;
    logic [IW-1:0]   plru_set;
    logic [WW-1:0]   plru_way;

    always_comb begin
        way_hit  = '0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid_q[idx][w] && (tag_mem[w][idx] == tag);
            if (way_hit[w]) begin
                hit_way  = WW'(w);
                hit_line = data_mem[w][idx];
            end
        end
    end

    assign any_hit       = |way_hit;
    assign bus.fetch_hit = bus.fetch_valid && (state_q == IDLE) && any_hit;
    assign bus.inst_out  = 32'(hit_line >> {off, 3'b000});
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_req   = (state_q == REFILL);
    assign bus.mem_addr  = bus.mem_req ? base_q + (ADDR_BITS'(cnt_q) << 2) : '0;

    // Lowest invalid way wins over the pseudo-LRU choice.
    always_comb begin
        new_vict = plru_vict;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) new_vict = WW'(w);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        vict_d   = vict_q;
        fill_d   = fill_q;
        drop_d   = drop_q;
        for (int s = 0; s < SETS; s++) valid_d[s] = valid_q[s];
        wr_en    = 1'b0;
        plru_upd = 1'b0;
        plru_set = idx;
        plru_way = hit_way;
        if (rdy_in) begin
            if (flush) begin
                for (int s = 0; s < SETS; s++) valid_d[s] = '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!flush && bus.fetch_valid) begin
                        if (any_hit) begin
                            plru_upd = (WAYS <= 2);
                        end else begin
                            state_d = REFILL;
                            cnt_d   = '0;
                            base_d  = {bus.fetch_addr[ADDR_BITS-1:OW], {OW{1'b0}}};
                            idx_d   = idx;
                            tag_d   = tag;
                            vict_d  = new_vict;
                            drop_d  = 1'b0;
                        end
                    end
                end
                REFILL: begin
                    // A flush mid-refill still drains the memory handshake.
                    if (flush) drop_d = 1'b1;
                    if (bus.mem_ack) begin
                        fill_d[{cnt_q, 5'd0} +: 32] = bus.mem_data;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(WORDS - 1)) state_d = WRITE;
                    end
                end
                WRITE: begin
                    state_d = IDLE;
                    if (!drop_q && !flush) begin
                        wr_en                 = 1'b1;
                        valid_d[idx_q][vict_q] = 1'b1;
                        plru_upd              = 1'b1;
                        plru_set              = idx_q;
                        plru_way              = vict_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            vict_q  <= '0;
            fill_q  <= '0;
            drop_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            vict_q  <= vict_d;
            fill_q  <= fill_d;
            drop_q  <= drop_d;
            for (int s = 0; s < SETS; s++) valid_q[s] <= valid_d[s];
        end
    end

    // Tag/data arrays are gated by valid and need no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[vict_q][idx_q]  <= tag_q;
            data_mem[vict_q][idx_q] <= fill_q[LW-1:0];
        end
    end

    icache_plru #(
        .WAYS(WAYS),
        .SETS(SETS)
    ) u_plru (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .clear  (flush),
        .upd    (plru_upd),
        .upd_set(plru_set),
        .upd_way(plru_way),
        .rd_set (idx),
        .victim (plru_vict)
    );
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: LRU-list reference model plus directed scenarios.
// Memory byte at address a is a[7:0] + a[15:8].
module tb_icache_assoc;
    logic clk_in, rst_in, rdy_in, flush;
    bit   auto_ack, man_ack, resp_en;
    int   nvec, nerr;
    logic [16:0] acked [$];

    icache_assoc_if bus ();

    icache_assoc dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .flush (flush),
        .bus   (bus)
    );

    function automatic logic [7:0] byte_at(logic [16:0] a);
        return a[7:0] + a[15:8];
    endfunction

    function automatic logic [31:0] word_at(logic [16:0] a);
        logic [16:0] a1, a2, a3;
        a1 = a + 17'd1;
        a2 = a + 17'd2;
        a3 = a + 17'd3;
        return {byte_at(a3), byte_at(a2), byte_at(a1), byte_at(a)};
    endfunction

    assign bus.mem_ack  = auto_ack | man_ack;
    assign bus.mem_data = word_at(bus.mem_addr);

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: per set, an MRU/LRU list of resident block numbers.
    int          m_phase, m_cnt;
    bit          m_drop;
    logic [16:0] m_base;
    logic [12:0] mru [32];
    logic [12:0] lru [32];
    int          nres [32];

    function automatic bit resident(logic [16:0] a);
        logic [12:0] b;
        int s;
        b = a[16:4];
        s = int'(b[4:0]);
        return (nres[s] >= 1 && mru[s] == b) || (nres[s] == 2 && lru[s] == b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic [12:0] b;
        int s;
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) begin
                m_phase = 0;
                m_cnt   = 0;
                m_drop  = 0;
                m_base  = '0;
                for (int i = 0; i < 32; i++) nres[i] = 0;
            end else if (rdy_in) begin
                case (m_phase)
                    0: begin
                        b = bus.fetch_addr[16:4];
                        s = int'(b[4:0]);
                        if (flush) begin
                            for (int i = 0; i < 32; i++) nres[i] = 0;
                        end else if (bus.fetch_valid) begin
                            if (resident(bus.fetch_addr)) begin
                                if (nres[s] == 2 && lru[s] == b) begin
                                    lru[s] = mru[s];
                                    mru[s] = b;
                                end
                            end else begin
                                m_phase = 1;
                                m_base  = {b, 4'b0};
                                m_cnt   = 0;
                                m_drop  = 0;
                            end
                        end
                    end
                    1: begin
                        if (flush) begin
                            for (int i = 0; i < 32; i++) nres[i] = 0;
                            m_drop = 1;
                        end
                        if (bus.mem_ack) begin
                            m_cnt++;
                            if (m_cnt == 5) m_phase = 2;
                        end
                    end
                    default: begin
                        b = m_base[16:4];
                        s = int'(b[4:0]);
                        if (flush) begin
                            for (int i = 0; i < 32; i++) nres[i] = 0;
                        end else if (!m_drop) begin
                            if (nres[s] == 0) begin
                                mru[s] = b;
                                nres[s] = 1;
                            end else begin
                                lru[s] = mru[s];
                                mru[s] = b;
                                nres[s] = 2;
                            end
                        end
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Compare process on every falling edge.
    initial begin
        bit e_hit;
        logic [16:0] e_addr;
        forever begin
            @(negedge clk_in);
            e_addr = (m_phase == 1) ? 17'(m_base + 17'(4 * m_cnt)) : 17'd0;
            e_hit  = bus.fetch_valid && m_phase == 0 && resident(bus.fetch_addr);
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("mem_req", 32'(bus.mem_req), 32'(m_phase == 1));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("fetch_hit", 32'(bus.fetch_hit), 32'(e_hit));
            if (e_hit) chk("inst_out", bus.inst_out, word_at(bus.fetch_addr));
        end
    end

    // Memory responder: alternate-cycle ack pulses while a request is up.
    initial begin
        forever begin
            @(negedge clk_in);
            auto_ack = resp_en && bus.mem_req && !auto_ack;
        end
    end

    initial begin
        forever begin
            @(posedge clk_in);
            if (!rst_in && rdy_in && bus.mem_ack && bus.mem_req)
                acked.push_back(bus.mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        nvec++;
        if (bus.busy) begin
            nerr++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", n);
        end
    endtask

    task automatic wait_acks(input int k);
        int n;
        n = 0;
        while (acked.size() < k && n < 300) begin
            tick();
            n++;
        end
        nvec++;
        if (acked.size() < k) begin
            nerr++;
            $display("FAIL wait_acks: got %0d acks want %0d", acked.size(), k);
        end
    endtask

    task automatic chk_seq(input string nm, input logic [16:0] start);
        chk({nm, "_count"}, 32'(acked.size()), 32'd5);
        for (int i = 0; i < 5 && i < acked.size(); i++)
            chk(nm, 32'(acked[i]), 32'(17'(start + 17'(4 * i))));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush = 1'b0;
        man_ack = 1'b0;
        resp_en = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr = '0;
        tick();
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h00100;
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_hit", 32'(bus.fetch_hit), 32'd0);
        rst_in = 1'b0;
        acked.delete();

        // Cold miss; fetch_addr wanders during the refill.
        tick();
        chk("cold_busy", 32'(bus.busy), 32'd1);
        bus.fetch_addr = 17'h001F0;
        wait_acks(3);
        bus.fetch_addr = 17'h00100;
        wait_idle();
        chk_seq("cold_seq", 17'h00100);
        chk("cold_hit", 32'(bus.fetch_hit), 32'd1);
        chk("cold_inst", bus.inst_out, 32'h04030201);

        // Instruction straddling into the next block.
        bus.fetch_addr = 17'h0010E;
        #1;
        chk("mis_hit", 32'(bus.fetch_hit), 32'd1);
        chk("mis_inst", bus.inst_out, 32'h1211100F);
        tick();
        chk("mis_busy", 32'(bus.busy), 32'd0);

        // Conflict in set 16.
        bus.fetch_addr = 17'h00300;
        tick();
        wait_idle();
        chk("c300_inst", bus.inst_out, 32'h06050403);
        bus.fetch_addr = 17'h00100;
        tick();
        bus.fetch_addr = 17'h00500;
        tick();
        wait_idle();
        chk("c500_inst", bus.inst_out, 32'h08070605);
        bus.fetch_addr = 17'h00100;
        #1;
        chk("c100_hit", 32'(bus.fetch_hit), 32'd1);
        bus.fetch_addr = 17'h00300;
        #1;
        chk("c300_evicted", 32'(bus.fetch_hit), 32'd0);
        bus.fetch_valid = 1'b0;
        tick();

        // Flush at refill word 2.
        acked.delete();
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h00700;
        tick();
        bus.fetch_valid = 1'b0;
        wait_acks(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        chk("fl_acks", 32'(acked.size()), 32'd5);
        bus.fetch_valid = 1'b1;
        #1;
        chk("fl_700_miss", 32'(bus.fetch_hit), 32'd0);
        bus.fetch_addr = 17'h00100;
        #1;
        chk("fl_100_miss", 32'(bus.fetch_hit), 32'd0);
        bus.fetch_valid = 1'b0;
        tick();

        // Pause mid-refill with acks pulsing.
        acked.delete();
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h02000;
        tick();
        bus.fetch_valid = 1'b0;
        wait_acks(2);
        rdy_in = 1'b0;
        repeat (5) tick();
        chk("rdy_addr", 32'(bus.mem_addr), 32'h02008);
        chk("rdy_busy", 32'(bus.busy), 32'd1);
        rdy_in = 1'b1;
        wait_idle();
        chk_seq("rdy_seq", 17'h02000);
        bus.fetch_valid = 1'b1;
        #1;
        chk("rdy_hit", 32'(bus.fetch_hit), 32'd1);
        chk("rdy_inst", bus.inst_out, 32'h23222120);
        bus.fetch_valid = 1'b0;
        tick();

        // Reset mid-refill, then a stray ack in IDLE.
        acked.delete();
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h04000;
        tick();
        bus.fetch_valid = 1'b0;
        wait_acks(1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_req", 32'(bus.mem_req), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_in = 1'b0;
        resp_en = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("late_ack_busy", 32'(bus.busy), 32'd0);
        resp_en = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h00100;
        #1;
        chk("arst_miss", 32'(bus.fetch_hit), 32'd0);
        tick();
        wait_idle();
        chk("arst_refill", bus.inst_out, 32'h04030201);

        // Last block: extra halfword wraps to address 0.
        acked.delete();
        bus.fetch_addr = 17'h1FFF0;
        tick();
        wait_idle();
        chk_seq("wrap_seq", 17'h1FFF0);
        bus.fetch_addr = 17'h1FFFE;
        #1;
        chk("wrap_hit", 32'(bus.fetch_hit), 32'd1);
        chk("wrap_inst", bus.inst_out, 32'h0100FEFD);

        // Flush and a miss together: no refill.
        bus.fetch_addr = 17'h06000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        chk("fl_miss_busy", 32'(bus.busy), 32'd0);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr = 17'h1FFFE;
        #1;
        chk("fl_idle_miss", 32'(bus.fetch_hit), 32'd0);
        bus.fetch_valid = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
